// File: rtl/tdm_demultiplexer.sv
// TDM receiver: steers serial samples into per-slot shadow registers, publishes
// each complete frame as one parallel word, and tracks frame alignment.
module tdm_demultiplexer #(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      frame_start,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      dout_valid,
    output logic [SEL_W-1:0]          slot,
    output logic                      locked,
    output logic                      sync_err
);

    typedef enum logic {HUNT, LOCK} state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

    state_t           state;
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic             frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            slot       <= '0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
            frame_done <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            sync_err   <= 1'b0;
            frame_done <= 1'b0;
            dout_valid <= frame_done;

            // Publish one edge after the last slot lands, so shadow already holds it.
            if (frame_done) begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    dout[i*WIDTH +: WIDTH] <= shadow[i];
                end
            end

            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (frame_start) begin
                            shadow[0] <= din;
                            slot      <= SLOT_ONE;
                            state     <= LOCK;
                            locked    <= 1'b1;
                        end
                    end
                    LOCK: begin
                        if (frame_start) begin
                            // Early start abandons the partial frame; it never completes.
                            if (slot != '0) begin
                                sync_err <= 1'b1;
                            end
                            shadow[0] <= din;
                            slot      <= SLOT_ONE;
                        end else if (slot == '0) begin
                            sync_err <= 1'b1;
                            slot     <= '0;
                            state    <= HUNT;
                            locked   <= 1'b0;
                        end else begin
                            shadow[slot] <= din;
                            slot         <= slot + 1'b1;
                            if (slot == LAST_SLOT) begin
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= HUNT;
                    end
                endcase
            end
        end
    end

endmodule
